// File: rtl/bus_arbiter_pkg.sv
// Shared widths, requester count and FSM encoding for the system-bus arbiter.
package bus_arbiter_pkg;

    localparam int ARB_REQ_NUM    = 4;
    localparam int BUS_ADDR_WIDTH = 16;
    localparam int MEM_WIDTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ALE  = 3'd1,
        ST_CMD  = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4
    } arb_state_e;

    // Modular increment used for both the search order and the pointer update.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, with wrap-around.
module bus_rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int N     = ARB_REQ_NUM,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan from the farthest offset down so the nearest request to ptr_i wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[IDX_W'(wrap_add(int'(ptr_i), k, N))]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(wrap_add(int'(ptr_i), k, N));
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting N_REQ requesters one five-cycle system-bus transaction at a time.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ = ARB_REQ_NUM
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ-1:0]                req_we,
    input  logic [N_REQ*BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*MEM_WIDTH-1:0]      req_wdata,
    output logic [N_REQ-1:0]                ack,
    output logic [MEM_WIDTH-1:0]            rdata,
    output logic                            busy,
    output logic                            ale_en,
    output logic                            bus_read_en,
    output logic                            bus_write_en,
    output logic [BUS_ADDR_WIDTH-1:0]       addr_input,
    output logic [MEM_WIDTH-1:0]            data_write,
    input  logic [MEM_WIDTH-1:0]            data_read
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e                state_q;
    logic [IDX_W-1:0]          ptr_q;
    logic [IDX_W-1:0]          id_q;
    logic                      we_q;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [MEM_WIDTH-1:0]      wdata_q;
    logic [MEM_WIDTH-1:0]      rdata_q;
    logic [N_REQ-1:0]          ack_q;
    logic                      busy_q;
    logic                      ale_q;
    logic                      rd_q;
    logic                      wr_q;

    logic [N_REQ-1:0]          eligible;
    logic                      pick_valid;
    logic [IDX_W-1:0]          pick_idx;

    // A requester being acknowledged this cycle must not win again immediately.
    assign eligible = req & ~ack_q;

    bus_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ale_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_ALE;
                        id_q    <= pick_idx;
                        we_q    <= req_we[pick_idx];
                        addr_q  <= req_addr[int'(pick_idx)*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
                        wdata_q <= req_wdata[int'(pick_idx)*MEM_WIDTH +: MEM_WIDTH];
                        busy_q  <= 1'b1;
                        ale_q   <= 1'b1;
                    end
                end
                ST_ALE: begin
                    state_q <= ST_CMD;
                    ale_q   <= 1'b0;
                    rd_q    <= ~we_q;
                    wr_q    <= we_q;
                end
                ST_CMD: begin
                    state_q <= ST_XFER;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
                ST_XFER: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    addr_q      <= '0;
                    wdata_q     <= '0;
                    ack_q[id_q] <= 1'b1;
                    ptr_q       <= IDX_W'(wrap_add(int'(id_q), 1, N_REQ));
                    if (!we_q) begin
                        rdata_q <= data_read;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ale_q   <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                end
            endcase
        end
    end

    assign ack          = ack_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign ale_en       = ale_q;
    assign bus_read_en  = rd_q;
    assign bus_write_en = wr_q;
    assign addr_input   = addr_q;
    assign data_write   = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a timeline model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = BUS_ADDR_WIDTH;
    localparam int DW = MEM_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            ale_en;
    logic            bus_read_en;
    logic            bus_write_en;
    logic [AW-1:0]   addr_input;
    logic [DW-1:0]   data_write;
    logic [DW-1:0]   data_read;

    // System-bus slave memory, indexed by the low address byte.
    logic [DW-1:0]   mem [256];

    // Reference model: phase counts cycles since grant (0 = idle, 1..4 = ALE..DONE).
    int              m_phase = 0;
    int              m_id    = 0;
    int              m_ptr   = 0;
    logic            m_we    = 1'b0;
    logic [AW-1:0]   m_addr  = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic [DW-1:0]   m_rdata = '0;
    logic [N-1:0]    m_ack   = '0;
    logic [DW-1:0]   ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    assign data_read = mem[addr_input[7:0]];

    bus_arbiter #(.N_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .rdata        (rdata),
        .busy         (busy),
        .ale_en       (ale_en),
        .bus_read_en  (bus_read_en),
        .bus_write_en (bus_write_en),
        .addr_input   (addr_input),
        .data_write   (data_write),
        .data_read    (data_read)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'((i * 257) ^ 16'h5A3C);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic s_rst, input logic [N-1:0] s_req, input logic [N-1:0] s_we,
                              input logic [N*AW-1:0] s_addr, input logic [N*DW-1:0] s_wdata);
        logic [N-1:0] new_ack;
        int           j;
        new_ack = '0;
        // A write strobe seen by the bus lands in memory even if reset follows.
        if (m_phase == 2 && m_we) ref_mem[m_addr[7:0]] = m_wdata;
        if (s_rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_rdata = '0;
            m_ack   = '0;
        end else begin
            if (m_phase == 4) begin
                new_ack[m_id] = 1'b1;
                m_ptr         = (m_id + 1) % N;
                if (!m_we) m_rdata = ref_mem[m_addr[7:0]];
                m_phase       = 0;
            end else if (m_phase != 0) begin
                m_phase++;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (m_phase == 0 && s_req[j] && !m_ack[j]) begin
                        m_id    = j;
                        m_we    = s_we[j];
                        m_addr  = s_addr[j*AW +: AW];
                        m_wdata = s_wdata[j*DW +: DW];
                        m_phase = 1;
                    end
                end
            end
            m_ack = new_ack;
        end
    endtask

    task automatic tick();
        logic            s_rst;
        logic            s_bwe;
        logic [N-1:0]    s_req;
        logic [N-1:0]    s_we;
        logic [N*AW-1:0] s_addr;
        logic [N*DW-1:0] s_wdata;
        logic [AW-1:0]   s_baddr;
        logic [DW-1:0]   s_bdw;
        s_rst   = rst;
        s_req   = req;
        s_we    = req_we;
        s_addr  = req_addr;
        s_wdata = req_wdata;
        s_bwe   = bus_write_en;
        s_baddr = addr_input;
        s_bdw   = data_write;
        @(posedge clk);
        #1;
        cyc++;
        if (s_bwe) mem[s_baddr[7:0]] = s_bdw;
        model_edge(s_rst, s_req, s_we, s_addr, s_wdata);
        check("ack",          32'(ack),          32'(m_ack));
        check("rdata",        32'(rdata),        32'(m_rdata));
        check("busy",         32'(busy),         32'(m_phase != 0));
        check("ale_en",       32'(ale_en),       32'(m_phase == 1));
        check("bus_read_en",  32'(bus_read_en),  32'(m_phase == 2 && !m_we));
        check("bus_write_en", 32'(bus_write_en), 32'(m_phase == 2 && m_we));
        check("addr_input",   32'(addr_input),   (m_phase != 0) ? 32'(m_addr) : 32'd0);
        check("data_write",   32'(data_write),   (m_phase != 0) ? 32'(m_wdata) : 32'd0);
        check("strobe_excl",  32'(32'(ale_en) + 32'(bus_read_en) + 32'(bus_write_en) <= 1), 32'd1);
    endtask

    task automatic run_txn(input int idx, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_we[idx]           = we;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = wd;
        req[idx]              = 1'b1;
        tick();
        req[idx] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack",  32'(ack),  32'd0);

        // Single read by requester 1
        req_we[1] = 1'b0;
        req_addr[1*AW +: AW] = 16'h0104;
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        check("s1_ale_c1", 32'(ale_en), 32'd1);
        tick();
        check("s1_rd_c2", 32'(bus_read_en), 32'd1);
        repeat (3) tick();
        check("s1_ack_c5",   32'(ack),   32'h2);
        check("s1_rdata_c5", 32'(rdata), 32'(init_word(8'h04)));

        // Single write by requester 2, then read it back
        req_we[2] = 1'b1;
        req_addr[2*AW +: AW]  = 16'h0030;
        req_wdata[2*DW +: DW] = 16'hA5A5;
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        check("s2_dw_c1", 32'(data_write), 32'hA5A5);
        tick();
        check("s2_wr_c2", 32'(bus_write_en), 32'd1);
        check("s2_dw_c2", 32'(data_write), 32'hA5A5);
        tick();
        check("s2_dw_c3", 32'(data_write), 32'hA5A5);
        tick();
        check("s2_dw_c4", 32'(data_write), 32'hA5A5);
        tick();
        check("s2_ack_c5", 32'(ack), 32'h4);
        tick();
        run_txn(2, 1'b0, 16'h0030, 16'h0000);
        check("s2_readback", 32'(rdata), 32'hA5A5);

        // All four requesting: grants 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(16'h0040 + i);
        req_we = '0;
        req    = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            repeat (5) tick();
            check("rr_order", 32'(ack), 32'(1 << (g % N)));
        end
        req = '0;
        tick();

        // Requester 0 re-requests while 3 is pending
        do_reset();
        req_we = '0;
        req[0] = 1'b1;
        tick();
        req_addr[3*AW +: AW] = 16'h0077;
        req[3] = 1'b1;
        repeat (4) tick();
        check("s4_ack0_first", 32'(ack), 32'h1);
        repeat (5) tick();
        check("s4_ack3_next", 32'(ack), 32'h8);
        repeat (5) tick();
        check("s4_ack0_after", 32'(ack), 32'h1);
        req = '0;
        tick();

        // Reset during CMD aborts the transaction
        req_addr[1*AW +: AW] = 16'h0022;
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        tick();
        check("s5_in_cmd", 32'(bus_read_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_idle_busy", 32'(busy), 32'd0);
        check("s5_strobes",   32'({ale_en, bus_read_en, bus_write_en}), 32'd0);
        check("s5_no_ack",    32'(ack), 32'd0);
        repeat (5) tick();
        check("s5_still_no_ack", 32'(ack), 32'd0);
        run_txn(2, 1'b0, 16'h0050, 16'h0000);
        check("s5_new_ack",   32'(ack),   32'h4);
        check("s5_new_rdata", 32'(rdata), 32'(init_word(8'h50)));

        // Address change during XFER is ignored
        tick();
        req_addr[1*AW +: AW] = 16'h0011;
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        repeat (2) tick();
        check("s6_addr_c3", 32'(addr_input), 32'h0011);
        req_addr[1*AW +: AW] = 16'hFFFF;
        tick();
        check("s6_addr_c4", 32'(addr_input), 32'h0011);
        tick();
        check("s6_ack",   32'(ack),   32'h2);
        check("s6_rdata", 32'(rdata), 32'(init_word(8'h11)));

        // Random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            req       = N'($urandom);
            req_we    = N'($urandom);
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
